// File: rtl/dsp_slice.sv
// Pipelined pre-add / multiply / post-add slice with per-group CE and sync reset.
// DSP_BCIN_CASCADE_EN enables the B_INPUT="CASCADE" selection of BCIN.
module dsp_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [17:0] BCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [7:0]  op_r, op;
  logic [17:0] a0_r, a0_s, a1_r, a1_s;
  logic [17:0] b0_in, b0_r, b0_s, b1_in, b1_r, b1_s;
  logic [17:0] d_r, d_s;
  logic [47:0] c_r, c_s;
  logic [35:0] mult, m_r, m_s;
  logic        cin_in, cin_r, cin_s;
  logic [47:0] x, z;
  logic [48:0] sum;
  logic [47:0] p_r, p_s;
  logic        co_r, co_s;

  always_ff @(posedge CLK) begin
    if (RSTOPMODE) op_r <= '0;
    else if (CEOPMODE) op_r <= OPMODE;
  end
  assign op = (OPMODEREG != 0) ? op_r : OPMODE;

`ifdef DSP_BCIN_CASCADE_EN
  assign b0_in = (B_INPUT == "CASCADE") ? BCIN : B;
`else
  logic unused_bcin;
  assign unused_bcin = ^{BCIN, (B_INPUT == "CASCADE")};
  assign b0_in = B;
`endif

  always_ff @(posedge CLK) begin
    if (RSTA) begin
      a0_r <= '0;
      a1_r <= '0;
    end else if (CEA) begin
      a0_r <= A;
      a1_r <= a0_s;
    end
  end
  assign a0_s = (A0REG != 0) ? a0_r : A;
  assign a1_s = (A1REG != 0) ? a1_r : a0_s;

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      b0_r <= '0;
      b1_r <= '0;
    end else if (CEB) begin
      b0_r <= b0_in;
      b1_r <= b1_in;
    end
  end
  assign b0_s = (B0REG != 0) ? b0_r : b0_in;
  assign b1_s = (B1REG != 0) ? b1_r : b1_in;

  always_ff @(posedge CLK) begin
    if (RSTD) d_r <= '0;
    else if (CED) d_r <= D;
  end
  assign d_s = (DREG != 0) ? d_r : D;

  always_ff @(posedge CLK) begin
    if (RSTC) c_r <= '0;
    else if (CEC) c_r <= C;
  end
  assign c_s = (CREG != 0) ? c_r : C;

  // Pre-adder wraps at 18 bits
  always_comb begin
    b1_in = b0_s;
    if (op[4]) b1_in = op[6] ? (d_s - b0_s) : (d_s + b0_s);
  end
  assign BCOUT = b1_s;

  assign mult = 36'(a1_s) * 36'(b1_s);
  always_ff @(posedge CLK) begin
    if (RSTM) m_r <= '0;
    else if (CEM) m_r <= mult;
  end
  assign m_s = (MREG != 0) ? m_r : mult;
  assign M   = m_s;

  assign cin_in = (CARRYINSEL == "CARRYIN") ? CARRYIN : op[5];
  always_ff @(posedge CLK) begin
    if (RSTCARRYIN) cin_r <= 1'b0;
    else if (CECARRYIN) cin_r <= cin_in;
  end
  assign cin_s = (CARRYINREG != 0) ? cin_r : cin_in;

  always_comb begin
    x = '0;
    unique case (op[1:0])
      2'd0: x = '0;
      2'd1: x = {12'd0, m_s};
      2'd2: x = p_s;
      2'd3: x = {d_s[11:0], a1_s, b1_s};
    endcase
  end

  always_comb begin
    z = '0;
    unique case (op[3:2])
      2'd0: z = '0;
      2'd1: z = PCIN;
      2'd2: z = p_s;
      2'd3: z = c_s;
    endcase
  end

  // Bit 48 is the carry (add) or borrow (subtract) out
  always_comb begin
    if (op[7]) sum = {1'b0, z} - ({1'b0, x} + 49'(cin_s));
    else       sum = {1'b0, z} + {1'b0, x} + 49'(cin_s);
  end

  always_ff @(posedge CLK) begin
    if (RSTP) begin
      p_r  <= '0;
      co_r <= 1'b0;
    end else if (CEP) begin
      p_r  <= sum[47:0];
      co_r <= sum[48];
    end
  end
  assign p_s  = (PREG != 0) ? p_r : sum[47:0];
  assign co_s = (CARRYOUTREG != 0) ? co_r : sum[48];

  assign P         = p_s;
  assign PCOUT     = p_s;
  assign CARRYOUT  = co_s;
  assign CARRYOUTF = co_s;

endmodule

// File: tb/tb_dsp_slice.sv
// Scoreboard bench for dsp_slice: expectations queued at drive time,
// popped and compared when the pipeline output is due.
module tb_dsp_slice;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic [17:0] BCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int n_cmp = 0;
  int n_err = 0;
  logic [48:0] sb[$];
  logic [48:0] e;

  always #5 CLK = ~CLK;

  dsp_slice dut (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
    .RSTM(RSTM), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN),
    .RSTOPMODE(RSTOPMODE), .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
    .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE), .M(M), .P(P), .PCOUT(PCOUT),
    .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = {8{v}};
  endtask

  task automatic test_reset;
    set_rst(1'b1);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'hFF;
    repeat (6) sb.push_back(49'd0);
    edges(1);
    set_rst(1'b0);
    e = sb.pop_front(); n_cmp++;
    if (M !== e[35:0]) begin n_err++; $display("FAIL rst_m: got %h want %h", M, e[35:0]); end
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL rst_p: got %h want %h", P, e[47:0]); end
    e = sb.pop_front(); n_cmp++;
    if (PCOUT !== e[47:0]) begin n_err++; $display("FAIL rst_pcout: got %h want %h", PCOUT, e[47:0]); end
    e = sb.pop_front(); n_cmp++;
    if (BCOUT !== e[17:0]) begin n_err++; $display("FAIL rst_bcout: got %h want %h", BCOUT, e[17:0]); end
    e = sb.pop_front(); n_cmp++;
    if (CARRYOUT !== e[0]) begin n_err++; $display("FAIL rst_co: got %b want %b", CARRYOUT, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (CARRYOUTF !== e[0]) begin n_err++; $display("FAIL rst_cof: got %b want %b", CARRYOUTF, e[0]); end
  endtask

  // Run directly after reset so exact latency is observable
  task automatic test_multiply;
    OPMODE = 8'h01; A = 18'd5; B = 18'd7;
    sb.push_back(49'(5 * 7));
    sb.push_back(49'(5 * 7));
    edges(2);
    e = sb.pop_front(); n_cmp++;
    if (M !== e[35:0]) begin n_err++; $display("FAIL mult_m_2edges: got %0d want %0d", M, e[35:0]); end
    edges(1);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL mult_p_3edges: got %0d want %0d", P, e[47:0]); end
  endtask

  task automatic test_hold;
    CEP = 1'b0; A = 18'd9;
    sb.push_back(49'd35);
    sb.push_back(49'(9 * 7));
    edges(3);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL hold_p: got %0d want %0d", P, e[47:0]); end
    e = sb.pop_front(); n_cmp++;
    if (M !== e[35:0]) begin n_err++; $display("FAIL hold_m: got %0d want %0d", M, e[35:0]); end
    RSTP = 1'b1;
    sb.push_back(49'd0);
    edges(1);
    RSTP = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL rstp_over_ce: got %0d want %0d", P, e[47:0]); end
    CEP = 1'b1;
  endtask

  task automatic test_preadd;
    OPMODE = 8'h51; D = 18'd10; B = 18'd3; A = 18'd4;
    sb.push_back(49'd7);
    sb.push_back(49'(4 * 7));
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if (BCOUT !== e[17:0]) begin n_err++; $display("FAIL presub_bcout: got %0d want %0d", BCOUT, e[17:0]); end
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL presub_p: got %0d want %0d", P, e[47:0]); end
    OPMODE = 8'h11;
    sb.push_back(49'(4 * 13));
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL preadd_p: got %0d want %0d", P, e[47:0]); end
    D = 18'd0; B = 18'h3FFFF; OPMODE = 8'h51;
    sb.push_back(49'd1);
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if (BCOUT !== e[17:0]) begin n_err++; $display("FAIL presub_wrap: got %h want %h", BCOUT, e[17:0]); end
  endtask

  task automatic test_c_carry;
    OPMODE = 8'h2D; A = 18'd2; B = 18'd3; C = 48'd100;
    sb.push_back(49'd107);
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL cadd_carry: got %0d want %0d", P, e[47:0]); end
    OPMODE = 8'h8D;
    sb.push_back(49'd94);
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if ({CARRYOUT, P} !== e) begin n_err++; $display("FAIL csub: got %h want %h", {CARRYOUT, P}, e); end
  endtask

  task automatic test_concat_wrap;
    OPMODE = 8'h0F; D = 18'd0; A = 18'd1; B = 18'd0; C = 48'hFFFFFFFFFFFF;
    sb.push_back({1'b1, 48'h3FFFF});
    edges(5);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL concat_p: got %h want %h", P, e[47:0]); end
    n_cmp++;
    if (CARRYOUT !== e[48]) begin n_err++; $display("FAIL concat_co: got %b want %b", CARRYOUT, e[48]); end
    n_cmp++;
    if (CARRYOUTF !== e[48]) begin n_err++; $display("FAIL concat_cof: got %b want %b", CARRYOUTF, e[48]); end
  endtask

  task automatic test_pcin_accum;
    OPMODE = 8'h04; PCIN = 48'h123456789ABC;
    sb.push_back({1'b0, 48'h123456789ABC});
    edges(4);
    e = sb.pop_front(); n_cmp++;
    if (PCOUT !== e[47:0]) begin n_err++; $display("FAIL pcin_pass: got %h want %h", PCOUT, e[47:0]); end
    OPMODE = 8'h09; A = 18'd3; B = 18'd4;
    edges(3);
    sb.push_back(49'(P) + 49'd36);
    edges(3);
    e = sb.pop_front(); n_cmp++;
    if (P !== e[47:0]) begin n_err++; $display("FAIL accum_p: got %h want %h", P, e[47:0]); end
  endtask

  initial begin
    set_rst(1'b0);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'hFF;
    A = '0; B = '0; D = '0; BCIN = 18'h2AAAA;
    C = '0; PCIN = '0; CARRYIN = 1'b0; OPMODE = '0;
    edges(1);
    test_reset;
    test_multiply;
    test_hold;
    test_preadd;
    test_c_carry;
    test_concat_wrap;
    test_pcin_accum;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_slice.md
DSP_SLICE -- requirements
Module: dsp_slice

Interface
REQ-001 Parameters, default, meaning: A0REG 0, A1REG 1, B0REG 0, B1REG 1 (pipeline stage present when 1); CREG, DREG, MREG, PREG, CARRYINREG, CARRYOUTREG, OPMODEREG all 1; CARRYINSEL "OPMODE5" (carry source, else "CARRYIN"); B_INPUT "DIRECT" (else "CASCADE").
REQ-002 Ports, name direction width meaning:
- CLK in 1: sole clock, rising edge.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE in 1 each: reset of the matching register group; synchronous, active-high.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE in 1 each: clock enable of the matching register group.
- A, B, D in 18: multiplier operand, pre-adder operand, pre-adder operand.
- BCIN in 18: cascaded B input.
- C in 48: post-adder operand.
- PCIN in 48: cascaded P input.
- CARRYIN in 1: external carry.
- OPMODE in 8: operation select.
- M out 36: multiplier result after MREG stage.
- P out 48, PCOUT out 48: post-adder result; PCOUT equals P.
- BCOUT out 18: B1-stage output.
- CARRYOUT out 1, CARRYOUTF out 1: post-adder carry; CARRYOUTF equals CARRYOUT.

Function
REQ-003 Every stage: parameter 1 registers the value (sync reset, then CE); parameter 0 passes it combinationally.
REQ-004 OPMODE passes through the OPMODEREG stage; all decoding uses the stage output.
REQ-005 B0 source: B (DIRECT) or BCIN (CASCADE); D passes DREG.
REQ-006 Pre-adder: OPMODE[4]=1 makes B1 input D-B0 when OPMODE[6]=1, D+B0 when 0, 18-bit wrap; OPMODE[4]=0 feeds B0 unchanged.
REQ-007 BCOUT = B1 output; multiplier = A1 x B1 unsigned, 36-bit, through MREG to M.
REQ-008 X mux OPMODE[1:0]: 0 zero, 1 zero-extended M, 2 P, 3 {D[11:0], A1, B1}.
REQ-009 Z mux OPMODE[3:2]: 0 zero, 1 PCIN, 2 P, 3 C after CREG.
REQ-010 Carry-in is OPMODE[5] ("OPMODE5") or CARRYIN ("CARRYIN"), through CARRYINREG.
REQ-011 Post-adder, 49-bit: OPMODE[7]=0 gives Z+X+CIN; 1 gives Z-(X+CIN); bits 47:0 go through PREG to P; bit 48 through CARRYOUTREG to CARRYOUT.
REQ-012 Default latency: A/B to M 2 edges; A/B to P 3 edges; C to P 2 edges; X=3 to P 2 edges.
REQ-013 Any CE low holds its register, all others advance; X=2 or Z=2 uses the P value held in that register.

Reset
REQ-014 Each RSTx clears its group to 0 on the next rising edge, overriding CE.
REQ-015 After every group is reset, M, P, PCOUT and BCOUT are 0, and CARRYOUT and CARRYOUTF are 0.

Configuration
REQ-016 Macro DSP_BCIN_CASCADE_EN.
- Defined: B_INPUT honoured per REQ-005.
- Undefined: B0 always takes B, BCIN ignored, B_INPUT has no effect.

Verification
REQ-017 Reset: all RSTx=1, all CE=1, one edge -> M=0, P=0, PCOUT=0, BCOUT=0, CARRYOUT=0.
REQ-018 Multiply: OPMODE=8'h01, A=5, B=7 -> M=35 after 2 edges, P=35 after 3.
REQ-019 Pre-subtract: OPMODE=8'h51, D=10, B=3, A=4 -> BCOUT=7, P=28.
REQ-020 C add with carry: OPMODE=8'h2D, A=2, B=3, C=100 -> P=107; then OPMODE=8'h8D -> P=94.
REQ-021 Concat wrap: OPMODE=8'h0F, D=0, A=1, B=0, C=48'hFFFFFFFFFFFF -> P=48'h3FFFF, CARRYOUT=1, CARRYOUTF=1.
REQ-022 Hold: after REQ-018, CEP=0 with A=9 -> P remains 35 and M becomes 63.
